// File: rtl/mole_if.sv
// rtl/mole_if.sv - whack-a-mole sequencer signal bundle
// master drives game inputs and observes results; slave is the sequencer.
interface mole_if;
   logic       start_game;
   logic [2:0] lfsr_output;
   logic [2:0] box_address;
   logic [2:0] target_box;
   logic       hit_pulse;
   logic       miss_pulse;
   logic [5:0] game_timer;
   logic       game_over;

   modport master (
      output start_game, lfsr_output, box_address,
      input  target_box, hit_pulse, miss_pulse, game_timer, game_over
   );

   modport slave (
      input  start_game, lfsr_output, box_address,
      output target_box, hit_pulse, miss_pulse, game_timer, game_over
   );
endinterface

// File: rtl/mole_sequencer.sv
// rtl/mole_sequencer.sv - whack-a-mole game sequencer
// Picks random boxes, times dwell and gap, scores synchronized box strikes, runs the game clock.
module mole_sequencer #(
   parameter int CLK_HZ       = 50000000,
   parameter int GAME_SECONDS = 60,
   parameter int DWELL_CYCLES = 50000000,
   parameter int GAP_CYCLES   = 12500000
) (
   input logic    CLOCK_50,
   input logic    reset,
   mole_if.slave  bus
);
   typedef enum logic [2:0] {LOBBY, PICK, SHOW, GAP, OVER} state_t;

   localparam logic [5:0]  GAME_INIT = 6'(GAME_SECONDS);
   localparam logic [31:0] PRESC_MAX = 32'(CLK_HZ - 1);
   localparam logic [31:0] DWELL_MAX = 32'(DWELL_CYCLES - 1);
   localparam logic [31:0] GAP_MAX   = 32'(GAP_CYCLES - 1);

   state_t      state;
   logic        start_prev;
   logic [2:0]  box_s1, box_s2, box_prev;
   logic [2:0]  target;
   logic [5:0]  timer;
   logic [31:0] presc, dwell_cnt, gap_cnt;

   logic start_rise, strike, lfsr_ok, dwell_done;

   assign start_rise = bus.start_game & ~start_prev;
   assign strike     = (box_s2 != box_prev) && (box_s2 != 3'd0);
   assign lfsr_ok    = (bus.lfsr_output != 3'd0) && (bus.lfsr_output != 3'd7) &&
                       (bus.lfsr_output != target);
   assign dwell_done = (dwell_cnt == DWELL_MAX);
   assign bus.game_timer = timer;

   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         state          <= LOBBY;
         start_prev     <= 1'b1;  // a start held high across reset must not look like an edge
         box_s1         <= 3'd0;
         box_s2         <= 3'd0;
         box_prev       <= 3'd0;
         target         <= 3'd0;
         timer          <= GAME_INIT;
         presc          <= 32'd0;
         dwell_cnt      <= 32'd0;
         gap_cnt        <= 32'd0;
         bus.target_box <= 3'd0;
         bus.hit_pulse  <= 1'b0;
         bus.miss_pulse <= 1'b0;
         bus.game_over  <= 1'b0;
      end else begin
         start_prev     <= bus.start_game;
         box_s1         <= bus.box_address;
         box_s2         <= box_s1;
         box_prev       <= box_s2;
         bus.hit_pulse  <= 1'b0;
         bus.miss_pulse <= 1'b0;

         if (state == LOBBY) begin
            bus.target_box <= 3'd0;
            bus.game_over  <= 1'b0;
            timer          <= GAME_INIT;
            presc          <= 32'd0;
            if (start_rise)
               state <= PICK;
         end else if (state == OVER) begin
            bus.target_box <= 3'd0;
            bus.game_over  <= 1'b1;
            timer          <= 6'd0;
            if (start_rise) begin
               state         <= LOBBY;
               timer         <= GAME_INIT;
               bus.game_over <= 1'b0;
            end
         end else if (timer == 6'd0) begin
            // Running out of time wins over any strike or timeout this cycle.
            state          <= OVER;
            bus.target_box <= 3'd0;
            bus.game_over  <= 1'b1;
         end else begin
            if (presc == PRESC_MAX) begin
               presc <= 32'd0;
               timer <= timer - 6'd1;
            end else begin
               presc <= presc + 32'd1;
            end

            case (state)
               PICK: begin
                  bus.target_box <= 3'd0;
                  if (lfsr_ok) begin
                     target         <= bus.lfsr_output;
                     bus.target_box <= bus.lfsr_output;
                     dwell_cnt      <= 32'd0;
                     state          <= SHOW;
                  end
               end
               SHOW: begin
                  dwell_cnt <= dwell_cnt + 32'd1;
                  if (strike && box_s2 == target) begin
                     bus.hit_pulse  <= 1'b1;
                     bus.target_box <= 3'd0;
                     gap_cnt        <= 32'd0;
                     state          <= GAP;
                  end else if (strike || dwell_done) begin
                     // A wrong strike on the expiry cycle still ends the dwell, with one miss.
                     bus.miss_pulse <= 1'b1;
                     if (dwell_done) begin
                        bus.target_box <= 3'd0;
                        gap_cnt        <= 32'd0;
                        state          <= GAP;
                     end
                  end
               end
               GAP: begin
                  bus.target_box <= 3'd0;
                  if (gap_cnt == GAP_MAX)
                     state <= PICK;
                  else
                     gap_cnt <= gap_cnt + 32'd1;
               end
               default: state <= LOBBY;
            endcase
         end
      end
   end
endmodule
